// File: rtl/psram_target.sv
// Octal-SPI (OPI, SDR) PSRAM target model with synchronized serial interface.
// Optional sticky protocol-error flag enabled by defining PSRAM_TARGET_ERR_EN.
module psram_target #(
    parameter int         MEM_DEPTH = 64,
    parameter logic [7:0] RD_CMD    = 8'h20,
    parameter logic [7:0] WR_CMD    = 8'hA0,
    parameter logic [7:0] CFG_CMD   = 8'hC0,
    parameter logic [3:0] LAT_RST   = 4'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    output logic [7:0] psram_io_out_o,
    output logic [7:0] psram_io_en_o,
    output logic [3:0] lat_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_CFG    = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    logic          sck_s1_q, sck_s2_q, sck_s3_q;
    logic          ce_s1_q, ce_s2_q, ce_s3_q;
    logic [7:0]    io_s1_q, io_s2_q;
    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    abyte_q, abyte_d;
    logic          is_wr_q, is_wr_d;
    logic          cfg_done_q, cfg_done_d;
    logic [3:0]    lat_q, lat_d;
    logic [7:0]    out_q, out_d;
    logic [7:0]    en_q, en_d;
    logic          mem_we;
    logic [7:0]    mem_q [MEM_DEPTH];

    logic sck_rise, sck_fall, ce_rise, ce_fall, cmd_known;

    assign sck_rise  = sck_s2_q & ~sck_s3_q & ~ce_s2_q;
    assign sck_fall  = ~sck_s2_q & sck_s3_q & ~ce_s2_q;
    assign ce_rise   = ce_s2_q & ~ce_s3_q;
    assign ce_fall   = ~ce_s2_q & ce_s3_q;
    assign cmd_known = (io_s2_q == RD_CMD) || (io_s2_q == WR_CMD) || (io_s2_q == CFG_CMD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
            ce_s1_q  <= 1'b1;
            ce_s2_q  <= 1'b1;
            ce_s3_q  <= 1'b1;
            io_s1_q  <= 8'h00;
            io_s2_q  <= 8'h00;
        end else begin
            sck_s1_q <= psram_sck_i;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            ce_s1_q  <= psram_ce_i;
            ce_s2_q  <= ce_s1_q;
            ce_s3_q  <= ce_s2_q;
            io_s1_q  <= psram_io_in_i;
            io_s2_q  <= io_s1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        abyte_d    = abyte_q;
        is_wr_d    = is_wr_q;
        cfg_done_d = cfg_done_q;
        lat_d      = lat_q;
        out_d      = out_q;
        en_d       = en_q;
        mem_we     = 1'b0;
        // CE release overrides any same-cycle sck edge
        if (ce_rise) begin
            state_d = S_IDLE;
            out_d   = 8'h00;
            en_d    = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: if (ce_fall) state_d = S_CMD;
                S_CMD: if (sck_rise) begin
                    abyte_d    = 2'd0;
                    cfg_done_d = 1'b0;
                    is_wr_d    = (io_s2_q == WR_CMD);
                    if (io_s2_q == RD_CMD || io_s2_q == WR_CMD) state_d = S_ADDR;
                    else if (io_s2_q == CFG_CMD)                state_d = S_CFG;
                    else                                        state_d = S_IGNORE;
                end
                S_ADDR: if (sck_rise) begin
                    abyte_d = abyte_q + 2'd1;
                    if (abyte_q == 2'd2) begin
                        // depth <= 256, so address mod depth comes from the low byte only
                        idx_d = io_s2_q[AW-1:0];
                        cnt_d = 4'd0;
                        if (is_wr_q)           state_d = S_WDATA;
                        else if (lat_q == 4'd0) state_d = S_RDATA;
                        else                    state_d = S_WAIT;
                    end
                end
                S_WAIT: if (sck_rise) begin
                    if (cnt_q == lat_q - 4'd1) state_d = S_RDATA;
                    else                       cnt_d   = cnt_q + 4'd1;
                end
                S_RDATA: if (sck_fall) begin
                    out_d = mem_q[idx_q];
                    en_d  = 8'hFF;
                    idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
                end
                S_WDATA: if (sck_rise) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + {{(AW-1){1'b0}}, 1'b1};
                end
                S_CFG: if (sck_rise && !cfg_done_q) begin
                    lat_d      = io_s2_q[3:0];
                    cfg_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= 4'd0;
            abyte_q    <= 2'd0;
            is_wr_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            lat_q      <= LAT_RST;
            out_q      <= 8'h00;
            en_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            abyte_q    <= abyte_d;
            is_wr_q    <= is_wr_d;
            cfg_done_q <= cfg_done_d;
            lat_q      <= lat_d;
            out_q      <= out_d;
            en_q       <= en_d;
        end
    end

    // Storage has no reset so contents survive both reset and CE cycling
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem_q[idx_q] <= io_s2_q;
    end

`ifdef PSRAM_TARGET_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ce_rise && (state_q == S_CMD || state_q == S_ADDR || state_q == S_WAIT))
            err_d = 1'b1;
        if (!ce_rise && state_q == S_CMD && sck_rise && !cmd_known)
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_cmd_known;
    assign unused_cmd_known = cmd_known;
    assign err_o = 1'b0;
`endif

    assign psram_io_out_o = out_q;
    assign psram_io_en_o  = en_q;
    assign lat_o          = lat_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_psram_target.sv
// Scoreboard bench for psram_target: bit-level initiator, byte model, queued read expectations.
module tb_psram_target;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       ce;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic [7:0] io_en;
    logic [3:0] lat;
    logic       busy;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    int         cur_lat = 4;
    logic [7:0] model [64];
    logic [7:0] exp_q [$];

    psram_target dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_in_i  (io_in),
        .psram_io_out_o (io_out),
        .psram_io_en_o  (io_en),
        .lat_o          (lat),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck period; read data is captured just before the rising edge
    task automatic sck_byte(input logic [7:0] b, output logic [7:0] r, output logic [7:0] en);
        io_in = b;
        tick(H);
        r   = io_out;
        en  = io_en;
        sck = 1'b1;
        tick(H);
        sck = 1'b0;
    endtask

    task automatic ce_start();
        ce = 1'b0;
        tick(4);
    endtask

    task automatic ce_end();
        tick(3);
        ce = 1'b1;
        tick(8);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] r, en;
        sck_byte(cmd, r, en);
        sck_byte(a[23:16], r, en);
        sck_byte(a[15:8], r, en);
        sck_byte(a[7:0], r, en);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3, input int n);
        logic [7:0] r, en;
        logic [7:0] d [4];
        logic [5:0] ix;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        ce_start();
        send_hdr(8'hA0, a);
        for (int k = 0; k < n; k++) begin
            sck_byte(d[k], r, en);
            ix = a[5:0] + 6'(k);
            model[ix] = d[k];
        end
        ce_end();
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        logic [7:0] r, en, e;
        logic [5:0] ix;
        for (int k = 0; k < n; k++) begin
            ix = a[5:0] + 6'(k);
            exp_q.push_back(model[ix]);
        end
        ce_start();
        send_hdr(8'h20, a);
        for (int k = 0; k < cur_lat; k++) sck_byte(8'h00, r, en);
        for (int k = 0; k < n; k++) begin
            sck_byte(8'h00, r, en);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL %s data[%0d]: got %h expected %h", tag, k, r, e);
            end
            checks++;
            if (en !== 8'hFF) begin
                errors++;
                $display("FAIL %s io_en[%0d]: got %h expected ff", tag, k, en);
            end
        end
        ce_end();
        checks++;
        if (io_en !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: io_en %h busy %b expected 00 0", tag, io_en, busy);
        end
    endtask

    task automatic do_cfg(input logic [7:0] v);
        logic [7:0] r, en;
        ce_start();
        sck_byte(8'hC0, r, en);
        sck_byte(v, r, en);
        sck_byte(8'h07, r, en);
        ce_end();
        cur_lat = int'(v[3:0]);
        checks++;
        if (lat !== v[3:0]) begin
            errors++;
            $display("FAIL cfg_lat: got %0d expected %0d", lat, v[3:0]);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        checks++;
        if (io_out !== 8'h00 || io_en !== 8'h00 || lat !== 4'd4 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s: out %h en %h lat %0d busy %b err %b expected 00 00 4 0 0",
                     tag, io_out, io_en, lat, busy, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sck = 1'b0; ce = 1'b1; io_in = 8'h00;
        tick(3);
        check_reset_outs("reset_held");
        rst = 1'b0;
        tick(3);
        check_reset_outs("reset_released");
    endtask

    task automatic test_write_read();
        do_write(24'h000010, 8'h11, 8'h22, 8'h33, 8'h00, 3);
        do_read(24'h000010, 3, "wr_rd");
    endtask

    task automatic test_wrap();
        do_write(24'h00003E, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 4);
        do_read(24'h00003E, 4, "wrap_rd");
        do_read(24'h000000, 2, "wrap_low");
        do_read(24'hABCD50, 3, "addr_mod");
    endtask

    task automatic test_cfg();
        do_cfg(8'h02);
        do_read(24'h000010, 2, "lat2_rd");
        do_cfg(8'h00);
        do_read(24'h00003F, 2, "lat0_rd");
        do_cfg(8'h04);
    endtask

    task automatic test_ignore();
        logic [7:0] r, en;
        ce_start();
        for (int k = 0; k < 4; k++) begin
            sck_byte(k == 0 ? 8'h55 : 8'h3C, r, en);
            checks++;
            if (en !== 8'h00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore_en[%0d]: en %h busy %b expected 00 1", k, en, busy);
            end
        end
        ce_end();
        checks++;
`ifdef PSRAM_TARGET_ERR_EN
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ignore_err: got %b expected 1", err);
        end
`else
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_err: got %b expected 0", err);
        end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] r, en;
        ce_start();
        sck_byte(8'h20, r, en);
        sck_byte(8'h00, r, en);
        sck_byte(8'h00, r, en);
        tick(2);
        ce = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || io_en !== 8'h00) begin
            errors++;
            $display("FAIL abort_idle: busy %b en %h expected 0 00", busy, io_en);
        end
        tick(6);
        do_read(24'h000010, 3, "after_abort");
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, en;
        ce_start();
        send_hdr(8'h20, 24'h000010);
        for (int k = 0; k < cur_lat + 2; k++) sck_byte(8'h00, r, en);
        checks++;
        if (io_en !== 8'hFF) begin
            errors++;
            $display("FAIL mid_rdata_en: got %h expected ff", io_en);
        end
        rst = 1'b1;
        tick(1);
        check_reset_outs("reset_mid");
        ce = 1'b1; sck = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(4);
        cur_lat = 4;
        do_read(24'h000010, 3, "mem_kept");
        do_read(24'h00003E, 4, "mem_kept_wrap");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_cfg();
        test_ignore();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_target.md
PSRAM_TARGET -- requirements
Module: psram_target

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, byte array depth (power of two, 16..256).
REQ-002 SHALL have parameter RD_CMD, default 8'h20, read command code.
REQ-003 SHALL have parameter WR_CMD, default 8'hA0, write command code.
REQ-004 SHALL have parameter CFG_CMD, default 8'hC0, latency-config command code.
REQ-005 SHALL have parameter LAT_RST, default 4, reset read latency in sck cycles.
REQ-006 clk_i  input  1  system clock; the only clock; at least 4x psram_sck_i frequency.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 psram_sck_i  input  1  serial clock from initiator, asynchronous.
REQ-009 psram_ce_i  input  1  chip enable, active low, asynchronous.
REQ-010 psram_io_in_i  input  8  octal data from initiator.
REQ-011 psram_io_out_o  output  8  octal read data to initiator.
REQ-012 psram_io_en_o  output  8  output enable per lane, all-ones while driving.
REQ-013 lat_o  output  4  current read latency.
REQ-014 busy_o  output  1  high while state is not IDLE.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL pass psram_sck_i, psram_ce_i, psram_io_in_i through 2-flop synchronizers; rising/falling sck edges SHALL be detected on the synchronized copy against a third register.
REQ-017 SHALL sample one byte per synchronized sck rising edge while synchronized CE is low (OPI, SDR).
REQ-018 States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, CFG, IGNORE.
REQ-019 IDLE -> CMD when synchronized CE falls; first rising edge byte is the command.
REQ-020 CMD: RD_CMD or WR_CMD -> ADDR; CFG_CMD -> CFG; any other -> IGNORE.
REQ-021 ADDR: three bytes, MSB first, form 24-bit address; array index = address mod MEM_DEPTH; after third byte, write -> WDATA, read -> WAIT (or RDATA if lat_o==0).
REQ-022 WAIT: count lat_o dummy rising edges, then RDATA.
REQ-023 RDATA: on each falling edge drive psram_io_out_o = mem[index], psram_io_en_o = 8'hFF, then index increments; initiator samples on next rising edge.
REQ-024 WDATA: each rising-edge byte written to mem[index], index increments.
REQ-025 Index SHALL wrap from MEM_DEPTH-1 to 0 in RDATA and WDATA with no error.
REQ-026 CFG: first data byte bits [3:0] load lat_o; further bytes ignored.
REQ-027 IGNORE: all bytes discarded, outputs not driven.
REQ-028 Synchronized CE rising in any state SHALL return to IDLE on the same clk_i cycle as detection, with psram_io_en_o = 0 and psram_io_out_o = 0 on the next cycle.
REQ-029 CE rising and an sck edge detected on the same cycle: CE wins, byte discarded.
REQ-030 Write byte and read never coincide (single transaction); memory contents persist across transactions and are not cleared by reset.

Reset
REQ-031 On rst_i high at a clk_i edge: state IDLE, psram_io_out_o 0, psram_io_en_o 0, lat_o LAT_RST, busy_o 0, err_o 0, index 0, synchronizers to CE high / sck low.
REQ-032 Reset asserted mid-transaction SHALL abort it; memory bytes already written remain.

Configuration
REQ-033 Macro PSRAM_TARGET_ERR_EN defined: err_o sets on unknown command (entering IGNORE) or CE rising during CMD/ADDR/WAIT with partial bytes; cleared only by reset.
REQ-034 Macro PSRAM_TARGET_ERR_EN undefined: err_o tied 0, no error logic compiled.

Verification
REQ-035 Write A0,00,00,10,11,22,33 then read 20,00,00,10, LAT 4 -> after 4 dummy edges out bytes 11,22,33.
REQ-036 Write 4 bytes at address 0x00003E (MEM_DEPTH 64) -> bytes land at 3E,3F,00,01; readback matches.
REQ-037 CFG C0,02 -> lat_o=2; subsequent read outputs first byte after 2 dummy edges.
REQ-038 Command 8'h55 with ERR_EN -> IGNORE, io_en stays 0, err_o=1; without macro err_o=0.
REQ-039 CE deasserted after second address byte -> busy_o 0 within 3 clk_i, io_en 0; next read correct.
REQ-040 rst_i pulsed during RDATA -> outputs at reset values next cycle, lat_o=4, memory preserved.
